axi4_lite_slave_regfile: RTL

AXI4-Lite responder that terminates the write-address, write-data, write-response, read-address and read-data channels driven by the team's AXI4-Lite master. It backs them with a bank of 32-bit software-visible registers. It accepts AW and W independently in either order, commits byte-strobed writes, returns OKAY/SLVERR responses, and serves single-outstanding reads. It sits between the master and the control/status registers of downstream blocks.

---
 rtl/axi4_lite_slave_regfile.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/axi4_lite_slave_regfile.sv
// axi4_lite_slave_regfile
// AXI4-Lite responder that backs a bank of NUM_REGS 32-bit registers.
// Write address and write data are each held in a one-entry buffer and may
// arrive in either order. A write commits once both buffers are full and no
// write response is still waiting. Reads are single-outstanding and return
// the register contents as they were before the read-address handshake.
// NUM_REGS is meant to stay within 1..256; register i lives at byte address 4*i.

module axi4_lite_slave_regfile #(
  parameter int NUM_REGS = 16
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [31:0] awaddr_slave_input,
  input  logic [2:0]  awprot_slave_input,
  input  logic        awvalid_slave_input,
  output logic        awready_slave_output,

  input  logic [31:0] wdata_slave_input,
  input  logic [3:0]  wstrb_slave_input,
  input  logic        wvalid_slave_input,
  output logic        wready_slave_output,

  output logic [1:0]  bresp_slave_output,
  output logic        bvalid_slave_output,
  input  logic        bready_slave_input,

  input  logic [31:0] araddr_slave_input,
  input  logic [2:0]  arprot_slave_input,
  input  logic        arvalid_slave_input,
  output logic        arready_slave_output,

  output logic [31:0] rdata_slave_output,
  output logic [1:0]  rresp_slave_output,
  output logic        rvalid_slave_output,
  input  logic        rready_slave_input
);

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] REG_COUNT   = 32'(NUM_REGS);

  // Write-address buffer (only the word index is kept; byte offset is ignored)
  logic        r_awFull;
  logic [29:0] r_awIdx;

  // Write-data buffer
  logic        r_wFull;
  logic [31:0] r_wData;
  logic [3:0]  r_wStrb;

  // Write-response channel
  logic        r_bValid;
  logic [1:0]  r_bResp;

  // Read-data channel
  logic        r_rValid;
  logic [1:0]  r_rResp;
  logic [31:0] r_rData;

  // Software-visible register bank
  logic [31:0] r_regs [NUM_REGS];

  // Handshake and decode wires
  logic        w_awHs;
  logic        w_wHs;
  logic        w_bHs;
  logic        w_arHs;
  logic        w_rHs;
  logic        w_commit;
  logic        w_wrLegal;
  logic        w_rdLegal;
  logic [29:0] w_rdIdx;
  logic [31:0] w_rdMux;
  logic        w_unused;

  // Protection bits and the byte offsets carry no meaning for a word-only
  // register file; they are folded together here so they are visibly consumed.
  assign w_unused = ^{awprot_slave_input, arprot_slave_input,
                      awaddr_slave_input[1:0], araddr_slave_input[1:0]};

  // Ready signals depend only on flop state and reset, never on a valid input.
  // Holding them low while reset is asserted keeps the master from handing
  // over a transfer that the reset would immediately discard.
  assign awready_slave_output = reset & ~r_awFull;
  assign wready_slave_output  = reset & ~r_wFull;
  assign arready_slave_output = reset & ~r_rValid;

  assign w_awHs = awvalid_slave_input & awready_slave_output;
  assign w_wHs  = wvalid_slave_input  & wready_slave_output;
  assign w_bHs  = r_bValid & bready_slave_input;
  assign w_arHs = arvalid_slave_input & arready_slave_output;
  assign w_rHs  = r_rValid & rready_slave_input;

  // A commit uses the registered bvalid, so a commit that was waiting on a
  // pending response happens on the edge after the B handshake, not on it.
  assign w_commit  = r_awFull & r_wFull & ~r_bValid;
  assign w_wrLegal = ({2'b00, r_awIdx} < REG_COUNT);

  assign w_rdIdx   = araddr_slave_input[31:2];
  assign w_rdLegal = ({2'b00, w_rdIdx} < REG_COUNT);

  assign bvalid_slave_output = r_bValid;
  assign bresp_slave_output  = r_bResp;
  assign rvalid_slave_output = r_rValid;
  assign rresp_slave_output  = r_rResp;
  assign rdata_slave_output  = r_rData;

  // Select the addressed register for a read; out-of-range indices read as 0.
  always_comb begin
    w_rdMux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_rdIdx == 30'(i)) begin
        w_rdMux = r_regs[i];
      end
    end
  end

  // Capture the write address and mark its buffer full; a commit frees it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_awFull <= 1'b0;
      r_awIdx  <= '0;
    end else if (w_awHs) begin
      r_awFull <= 1'b1;
      r_awIdx  <= awaddr_slave_input[31:2];
    end else if (w_commit) begin
      r_awFull <= 1'b0;
    end
  end

  // Capture write data and strobes and mark that buffer full; a commit frees it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wFull <= 1'b0;
      r_wData <= '0;
      r_wStrb <= '0;
    end else if (w_wHs) begin
      r_wFull <= 1'b1;
      r_wData <= wdata_slave_input;
      r_wStrb <= wstrb_slave_input;
    end else if (w_commit) begin
      r_wFull <= 1'b0;
    end
  end

  // Raise the write response on commit and hold it until the master takes it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bValid <= 1'b0;
      r_bResp  <= RESP_OKAY;
    end else if (w_commit) begin
      r_bValid <= 1'b1;
      r_bResp  <= w_wrLegal ? RESP_OKAY : RESP_SLVERR;
    end else if (w_bHs) begin
      r_bValid <= 1'b0;
    end
  end

  // Update the strobed byte lanes of the addressed register on a legal commit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit && w_wrLegal) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (r_awIdx == 30'(i)) begin
          for (int b = 0; b < 4; b++) begin
            if (r_wStrb[b]) begin
              r_regs[i][8*b +: 8] <= r_wData[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Latch read data and response on the address handshake and hold them until
  // rready; the mux sees the pre-edge register value, so a same-edge write
  // commit to the same register is not visible to this read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rValid <= 1'b0;
      r_rResp  <= RESP_OKAY;
      r_rData  <= '0;
    end else if (w_arHs) begin
      r_rValid <= 1'b1;
      r_rResp  <= w_rdLegal ? RESP_OKAY : RESP_SLVERR;
      r_rData  <= w_rdLegal ? w_rdMux : 32'h0000_0000;
    end else if (w_rHs) begin
      r_rValid <= 1'b0;
    end
  end

endmodule
